// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with a one-entry registered result slot per requester.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int FW    = 4
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req_valid0,
    output logic             req_ready0,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [4:0]       req_shamt0,
    input  logic [FW-1:0]    req_f0,
    output logic             rsp_valid0,
    input  logic             rsp_ready0,
    output logic [WIDTH-1:0] rsp_y0,
    output logic             rsp_zero0,

    input  logic             req_valid1,
    output logic             req_ready1,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [4:0]       req_shamt1,
    input  logic [FW-1:0]    req_f1,
    output logic             rsp_valid1,
    input  logic             rsp_ready1,
    output logic [WIDTH-1:0] rsp_y1,
    output logic             rsp_zero1,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [4:0]       alu_shamt,
    output logic [FW-1:0]    alu_f,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_zero
);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

    slot_e            slot0_q, slot0_d;
    slot_e            slot1_q, slot1_d;
    logic [WIDTH-1:0] y0_q, y0_d;
    logic [WIDTH-1:0] y1_q, y1_d;
    logic             zero0_q, zero0_d;
    logic             zero1_q, zero1_d;
    logic             last_grant_q, last_grant_d;

    logic             free0, free1;
    logic             elig0, elig1;
    logic             grant0, grant1;

    always_comb begin
        // A slot being drained this cycle may be refilled on the same edge.
        free0  = (slot0_q == SLOT_EMPTY) | rsp_ready0;
        free1  = (slot1_q == SLOT_EMPTY) | rsp_ready1;
        elig0  = req_valid0 & free0;
        elig1  = req_valid1 & free1;
        grant0 = elig0 & (~elig1 | last_grant_q);
        grant1 = elig1 & (~elig0 | ~last_grant_q);
    end

    always_comb begin
        alu_a     = '0;
        alu_b     = '0;
        alu_shamt = '0;
        alu_f     = '0;
        if (grant0) begin
            alu_a     = req_a0;
            alu_b     = req_b0;
            alu_shamt = req_shamt0;
            alu_f     = req_f0;
        end else if (grant1) begin
            alu_a     = req_a1;
            alu_b     = req_b1;
            alu_shamt = req_shamt1;
            alu_f     = req_f1;
        end
    end

    always_comb begin
        slot0_d      = slot0_q;
        slot1_d      = slot1_q;
        y0_d         = y0_q;
        y1_d         = y1_q;
        zero0_d      = zero0_q;
        zero1_d      = zero1_q;
        last_grant_d = last_grant_q;

        if (grant0) begin
            slot0_d      = SLOT_FULL;
            y0_d         = alu_y;
            zero0_d      = alu_zero;
            last_grant_d = 1'b0;
        end else if (slot0_q == SLOT_FULL && rsp_ready0) begin
            slot0_d = SLOT_EMPTY;
        end

        if (grant1) begin
            slot1_d      = SLOT_FULL;
            y1_d         = alu_y;
            zero1_d      = alu_zero;
            last_grant_d = 1'b1;
        end else if (slot1_q == SLOT_FULL && rsp_ready1) begin
            slot1_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot0_q      <= SLOT_EMPTY;
            slot1_q      <= SLOT_EMPTY;
            y0_q         <= '0;
            y1_q         <= '0;
            zero0_q      <= 1'b0;
            zero1_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            slot0_q      <= slot0_d;
            slot1_q      <= slot1_d;
            y0_q         <= y0_d;
            y1_q         <= y1_d;
            zero0_q      <= zero0_d;
            zero1_q      <= zero1_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign req_ready0 = grant0;
    assign req_ready1 = grant1;
    assign rsp_valid0 = (slot0_q == SLOT_FULL);
    assign rsp_valid1 = (slot1_q == SLOT_FULL);
    assign rsp_y0     = y0_q;
    assign rsp_y1     = y1_q;
    assign rsp_zero0  = zero0_q;
    assign rsp_zero1  = zero1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a stub ALU, a transaction-level arbitration
// model that queues expected results, and a monitor that checks delivered results.
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Requester-side stimulus, indexed by port.
    logic        v   [2];
    logic [31:0] a   [2];
    logic [31:0] b   [2];
    logic [4:0]  sh  [2];
    logic [3:0]  f   [2];
    logic        rr  [2];

    logic        req_ready0, req_ready1, rsp_valid0, rsp_valid1, rsp_zero0, rsp_zero1;
    logic [31:0] rsp_y0, rsp_y1, alu_a, alu_b, alu_y;
    logic [4:0]  alu_shamt;
    logic [3:0]  alu_f;
    logic        alu_zero;

    alu_arbiter #(.WIDTH(32), .FW(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid0(v[0]), .req_ready0(req_ready0), .req_a0(a[0]), .req_b0(b[0]),
        .req_shamt0(sh[0]), .req_f0(f[0]), .rsp_valid0(rsp_valid0), .rsp_ready0(rr[0]),
        .rsp_y0(rsp_y0), .rsp_zero0(rsp_zero0),
        .req_valid1(v[1]), .req_ready1(req_ready1), .req_a1(a[1]), .req_b1(b[1]),
        .req_shamt1(sh[1]), .req_f1(f[1]), .rsp_valid1(rsp_valid1), .rsp_ready1(rr[1]),
        .rsp_y1(rsp_y1), .rsp_zero1(rsp_zero1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_f(alu_f),
        .alu_y(alu_y), .alu_zero(alu_zero)
    );

    function automatic logic [31:0] alu_fn(input logic [3:0] fc, input logic [31:0] x,
                                           input logic [31:0] y, input logic [4:0] s);
        case (fc)
            4'd0:    return x & y;
            4'd1:    return x | y;
            4'd2:    return x + y;
            4'd3:    return y << s;
            4'd4:    return y >> s;
            4'd5:    return $unsigned($signed(y) >>> s);
            4'd6:    return x - y;
            4'd7:    return {31'd0, $signed(x) < $signed(y)};
            4'd8:    return ~(x | y);
            4'd9:    return x ^ y;
            4'd10:   return {31'd0, x < y};
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        alu_y    = alu_fn(alu_f, alu_a, alu_b, alu_shamt);
        alu_zero = (alu_y == 32'd0);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference state: slot occupancy, priority, outstanding results per port.
    logic        m_full [2];
    int unsigned m_last;
    logic        m_grant[2];
    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];
    logic        rv[2];
    logic        gr[2];

    always_comb begin
        rv[0] = rsp_valid0; rv[1] = rsp_valid1;
        gr[0] = req_ready0; gr[1] = req_ready1;
    end

    // Called once per cycle after inputs settle and before the next rising edge.
    task automatic model_step();
        logic        elig[2];
        logic [31:0] ey;
        int          w;
        for (int n = 0; n < 2; n++) elig[n] = v[n] && (!m_full[n] || rr[n]);
        if (elig[0] && elig[1]) w = (m_last == 0) ? 1 : 0;
        else if (elig[0])       w = 0;
        else if (elig[1])       w = 1;
        else                    w = -1;
        for (int n = 0; n < 2; n++) begin
            m_grant[n] = (w == n);
            chk($sformatf("req_ready%0d", n), {95'd0, gr[n]}, {95'd0, m_grant[n]});
            chk($sformatf("rsp_valid%0d", n), {95'd0, rv[n]}, {95'd0, m_full[n]});
        end
        if (w < 0)
            chk("alu_idle", {alu_a, alu_b, alu_shamt, alu_f}, 96'd0);
        else
            chk("alu_mux", {alu_a, alu_b, alu_shamt, alu_f}, {a[w], b[w], sh[w], f[w]});
        if (w >= 0) begin
            ey = alu_fn(f[w], a[w], b[w], sh[w]);
            if (w == 0) exp_q0.push_back({ey, ey == 32'd0});
            else        exp_q1.push_back({ey, ey == 32'd0});
            m_last = w;
        end
        for (int n = 0; n < 2; n++) m_full[n] = m_grant[n] || (m_full[n] && !rr[n]);
    endtask

    task automatic model_reset();
        m_full[0] = 1'b0; m_full[1] = 1'b0;
        m_grant[0] = 1'b0; m_grant[1] = 1'b0;
        m_last = 1;
        exp_q0.delete();
        exp_q1.delete();
    endtask

    // Monitor: compare each presented result against the oldest expected one.
    always @(negedge clk) begin
        if (!reset) begin
            if (rsp_valid0) begin
                if (exp_q0.size() == 0) chk("rsp0_unexpected", 96'd1, 96'd0);
                else begin
                    chk("rsp0", {rsp_y0, rsp_zero0}, exp_q0[0]);
                    if (rr[0]) void'(exp_q0.pop_front());
                end
            end
            if (rsp_valid1) begin
                if (exp_q1.size() == 0) chk("rsp1_unexpected", 96'd1, 96'd0);
                else begin
                    chk("rsp1", {rsp_y1, rsp_zero1}, exp_q1[0]);
                    if (rr[1]) void'(exp_q1.pop_front());
                end
            end
        end
    end

    task automatic set_port(input int n, input logic vv, input logic [31:0] aa,
                            input logic [31:0] bb, input logic [4:0] ss,
                            input logic [3:0] ff, input logic rdy);
        v[n] = vv; a[n] = aa; b[n] = bb; sh[n] = ss; f[n] = ff; rr[n] = rdy;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
        model_step();
    endtask

    initial begin
        reset = 1'b1;
        model_reset();
        set_port(0, 0, 0, 0, 0, 0, 1);
        set_port(1, 0, 0, 0, 0, 0, 1);
        #12;
        chk("reset_state", {rsp_valid0, rsp_valid1, rsp_y0, rsp_y1, rsp_zero0, rsp_zero1},
            96'd0);
        cycle();
        reset = 1'b0;

        // 1: single add on port 0
        cycle(); set_port(0, 1, 5, 3, 0, 4'b0010, 1); settle();
        cycle(); set_port(0, 0, 0, 0, 0, 0, 1); settle();
        chk("t1_y0", {rsp_valid0, rsp_y0, rsp_zero0}, {1'b1, 32'd8, 1'b0});

        // 2: both ports always valid and consuming
        for (int i = 0; i < 6; i++) begin
            cycle();
            set_port(0, 1, 7, 7, 0, 4'b0110, 1);
            set_port(1, 1, 1, 2, 0, 4'b0001, 1);
            settle();
        end
        cycle(); set_port(0, 0, 0, 0, 0, 0, 1); set_port(1, 0, 0, 0, 0, 0, 1); settle();

        // 3: port 0 holds result 8 while port 1 streams
        cycle(); set_port(0, 1, 5, 3, 0, 4'b0010, 1); settle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            set_port(0, 1, 32'h1234, 1, 0, 4'b0010, 0);
            set_port(1, 1, 0, 1, 4, 4'b0011, 1);
            settle();
            if (i > 0) chk("t3_y0_hold", rsp_y0, 32'd8);
        end
        chk("t3_y1", rsp_y1, 32'd16);

        // 4: consume and refill port 0 in the same cycle
        cycle();
        set_port(0, 1, 32'hF0F0F0F0, 32'hFFFFFFFF, 0, 4'b1001, 1);
        set_port(1, 0, 0, 0, 0, 0, 1);
        settle();
        cycle(); set_port(0, 0, 0, 0, 0, 0, 0); settle();
        chk("t4_y0", {rsp_valid0, rsp_y0}, {1'b1, 32'h0F0F0F0F});

        // 6: unused function code and idle mux
        cycle(); set_port(1, 1, 32'hDEAD, 32'hBEEF, 3, 4'b1111, 0); settle();
        cycle(); set_port(1, 0, 0, 0, 0, 0, 0); settle();
        chk("t6_y1", {rsp_y1, rsp_zero1}, {32'd0, 1'b1});

        // 5: asynchronous reset with both slots full
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("t5_async", {rsp_valid0, rsp_valid1}, 96'd0);
        model_reset();
        cycle(); reset = 1'b0;
        cycle();
        set_port(0, 1, 9, 1, 0, 4'b0010, 1);
        set_port(1, 1, 9, 2, 0, 4'b0010, 1);
        settle();
        chk("t5_first_grant", {req_ready0, req_ready1}, 96'b10);

        // random phase
        for (int i = 0; i < 400; i++) begin
            cycle();
            for (int n = 0; n < 2; n++) begin
                if (!(v[n] && !m_grant[n])) begin
                    v[n]  = ($urandom_range(3) != 0);
                    a[n]  = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
                    b[n]  = ($urandom_range(3) == 0) ? a[n] : $urandom;
                    sh[n] = 5'($urandom_range(31));
                    f[n]  = 4'($urandom_range(15));
                end
                rr[n] = ($urandom_range(3) != 0);
            end
            settle();
        end
        cycle(); set_port(0, 0, 0, 0, 0, 0, 1); set_port(1, 0, 0, 0, 0, 0, 1); settle();
        cycle(); settle();
        chk("drain_q0", exp_q0.size(), 0);
        chk("drain_q1", exp_q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
